// File: rtl/segre_assoc_cache.sv
// segre_assoc_cache: N-way set-associative, write-back, write-allocate data cache with round-robin replacement
//   clk_i, rst_i (async, active-high)
//   LSU side : req_valid_i/req_ready_o handshake, req_we_i, req_type_i, req_addr_i, req_wdata_i;
//              rsp_valid_o one-cycle pulse with rsp_rdata_o (zero-extended load data, 0 for stores)
//   Mem side : mem_req_o held until mem_gnt_i pulse; mem_we_o=1 writeback of mem_wline_o, 0 refill from mem_rline_i;
//              mem_addr_o line aligned
package segre_cache_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memop_data_type_e;
endpackage

module segre_assoc_cache
    import segre_cache_pkg::*;
#(
    parameter int WORD_SIZE  = 32,
    parameter int LINE_BYTES = 16,
    parameter int NUM_SETS   = 4,
    parameter int NUM_WAYS   = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  memop_data_type_e        req_type_i,
    input  logic [WORD_SIZE-1:0]    req_addr_i,
    input  logic [WORD_SIZE-1:0]    req_wdata_i,
    output logic                    rsp_valid_o,
    output logic [WORD_SIZE-1:0]    rsp_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [WORD_SIZE-1:0]    mem_addr_o,
    output logic [LINE_BYTES*8-1:0] mem_wline_o,
    input  logic                    mem_gnt_i,
    input  logic [LINE_BYTES*8-1:0] mem_rline_i
);
    localparam int OFF_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int TAG_W = WORD_SIZE - IDX_W - OFF_W;
    localparam int WAY_W = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int LW    = LINE_BYTES * 8;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_e;

    state_e              state_q;
    logic [TAG_W-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [LW-1:0]       data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [WAY_W-1:0]    ptr_q   [NUM_SETS];
    logic [WAY_W-1:0]    victim_q;
    logic [WORD_SIZE-1:0] addr_q, wdata_q, rsp_rdata_q, mem_addr_q;
    logic                we_q, rsp_valid_q, mem_req_q, mem_we_q;
    memop_data_type_e    type_q;
    logic [LW-1:0]       mem_wline_q;

    logic [TAG_W-1:0]     tag;
    logic [IDX_W-1:0]     idx;
    logic [OFF_W-1:0]     off;
    logic                 hit;
    logic [WAY_W-1:0]     hit_way, victim_d;
    logic [WORD_SIZE-1:0] size_mask, rdata_d;
    logic [LW-1:0]        hit_line, byte_mask, line_d;
    logic                 store_hit, refill_done;

    assign tag         = addr_q[WORD_SIZE-1 -: TAG_W];
    assign idx         = addr_q[OFF_W +: IDX_W];
    // Halfwords and words are forced onto their natural alignment so an access never crosses a line.
    assign off         = addr_q[OFF_W-1:0] & ~OFF_W'(type_q == WORD ? 3 : type_q == HALF ? 1 : 0);
    assign size_mask   = type_q == BYTE ? WORD_SIZE'('hFF) : type_q == HALF ? WORD_SIZE'('hFFFF) : '1;
    assign hit_line    = data_q[idx][hit_way];
    assign rdata_d     = we_q ? '0 : WORD_SIZE'(hit_line >> {off, 3'b000}) & size_mask;
    assign byte_mask   = LW'(size_mask) << {off, 3'b000};
    assign line_d      = (hit_line & ~byte_mask) | (LW'(wdata_q & size_mask) << {off, 3'b000});
    assign store_hit   = state_q == LOOKUP && hit && we_q;
    assign refill_done = state_q == REFILL && mem_gnt_i;

    // Descending scan leaves the lowest-index invalid way as victim; the round-robin pointer is used only when the set is full.
    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        victim_d = ptr_q[idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) victim_d = WAY_W'(w);
        end
    end

    always_ff @(posedge clk_i) begin
        if (store_hit) data_q[idx][hit_way] <= line_d;
        if (refill_done) begin
            data_q[idx][victim_q] <= mem_rline_i;
            tag_q[idx][victim_q]  <= tag;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
            victim_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            type_q      <= BYTE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wline_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    we_q    <= req_we_i;
                    type_q  <= req_type_i;
                    state_q <= LOOKUP;
                end
                LOOKUP: if (hit) begin
                    if (we_q) dirty_q[idx][hit_way] <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= rdata_d;
                    state_q     <= RESPOND;
                end else begin
                    // A dirty way is always valid, so the dirty bit alone decides whether to write back first.
                    victim_q    <= victim_d;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= dirty_q[idx][victim_d];
                    mem_addr_q  <= {(dirty_q[idx][victim_d] ? tag_q[idx][victim_d] : tag), idx, {OFF_W{1'b0}}};
                    mem_wline_q <= data_q[idx][victim_d];
                    state_q     <= dirty_q[idx][victim_d] ? WRITEBACK : REFILL;
                end
                WRITEBACK: if (mem_gnt_i) begin
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
                    state_q    <= REFILL;
                end
                REFILL: if (mem_gnt_i) begin
                    mem_req_q                <= 1'b0;
                    valid_q[idx][victim_q]   <= 1'b1;
                    dirty_q[idx][victim_q]   <= 1'b0;
                    if (valid_q[idx][victim_q]) ptr_q[idx] <= ptr_q[idx] == WAY_W'(NUM_WAYS - 1) ? '0 : ptr_q[idx] + 1'b1;
                    state_q                  <= LOOKUP;
                end
                RESPOND: begin
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready_o = state_q == IDLE;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wline_o = mem_wline_q;
endmodule

// File: tb/tb_segre_assoc_cache.sv
// tb_segre_assoc_cache: randomized and directed check of segre_assoc_cache against an architectural memory model
module tb_segre_assoc_cache;
    import segre_cache_pkg::*;

    typedef struct {
        bit           ready, rsp, req, we, gnt;
        logic [31:0]  rdata, addr;
        logic [127:0] line;
    } cyc_t;

    logic             clk_i = 1'b0, rst_i = 1'b1;
    logic             req_valid_i = 1'b0, req_we_i = 1'b0;
    memop_data_type_e req_type_i = BYTE;
    logic [31:0]      req_addr_i = '0, req_wdata_i = '0;
    logic             req_ready_o, rsp_valid_o, mem_req_o, mem_we_o;
    logic [31:0]      rsp_rdata_o, mem_addr_o;
    logic [127:0]     mem_wline_o, mem_rline_i = '0;
    logic             mem_gnt_i = 1'b0;

    segre_assoc_cache dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_type_i(req_type_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wline_o(mem_wline_o), .mem_gnt_i(mem_gnt_i), .mem_rline_i(mem_rline_i)
    );

    always #5 clk_i = ~clk_i;

    int total = 0, bad = 0;
    bit chk_en = 0;
    cyc_t ex;

    // Architectural view (gmem: what a load must return) and backing memory (bmem: what the arbiter side holds).
    logic [7:0]  gmem [int unsigned];
    logic [7:0]  bmem [int unsigned];
    bit          mv [4][2], md [4][2];
    logic [25:0] mt [4][2];
    int          mp [4];

    bit           last_miss;
    logic [31:0]  last_rdata, last_wb_addr, last_rf_addr;
    logic [127:0] last_wline;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic logic [7:0] gget(input int unsigned a);
        return gmem.exists(a) ? gmem[a] : a[7:0];
    endfunction

    function automatic logic [7:0] bget(input int unsigned a);
        return bmem.exists(a) ? bmem[a] : a[7:0];
    endfunction

    function automatic logic [127:0] gline(input int unsigned la);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = gget(la + k);
        return l;
    endfunction

    function automatic logic [127:0] bline(input int unsigned la);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) l[8*k +: 8] = bget(la + k);
        return l;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t mk(input bit ready, rsp, req, we, gnt, input logic [31:0] rdata, addr, input logic [127:0] line);
        cyc_t e;
        e.ready = ready; e.rsp = rsp; e.req = req; e.we = we; e.gnt = gnt;
        e.rdata = rdata; e.addr = addr; e.line = line;
        return e;
    endfunction

    always @(negedge clk_i) if (chk_en) begin
        chk("req_ready", req_ready_o, ex.ready);
        chk("rsp_valid", rsp_valid_o, ex.rsp);
        if (ex.rsp) chk("rsp_rdata", rsp_rdata_o, ex.rdata);
        chk("mem_req", mem_req_o, ex.req);
        if (ex.req) begin
            chk("mem_we", mem_we_o, ex.we);
            chk("mem_addr", mem_addr_o, ex.addr);
            if (ex.we) chk("mem_wline", mem_wline_o, ex.line);
        end
    end

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            mp[s] = 0;
            for (int w = 0; w < 2; w++) begin
                mv[s][w] = 0;
                md[s][w] = 0;
            end
        end
        // Dirty data held only in the cache is lost on reset.
        gmem.delete();
        foreach (bmem[k]) gmem[k] = bmem[k];
    endtask

    task automatic do_reset();
        chk_en = 0;
        req_valid_i = 0;
        mem_gnt_i = 0;
        rst_i = 1;
        #1;
        chk("async reset mem_req", mem_req_o, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        model_reset();
        ex = mk(1, 0, 0, 0, rb(), 0, 0, 0);
        mem_gnt_i = ex.gnt;
        chk_en = 1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            ex = mk(1, 0, 0, 0, rb(), 0, 0, 0);
            mem_gnt_i = ex.gnt;
            req_valid_i = 0;
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic do_req(input bit we, input int ty, input logic [31:0] a, input logic [31:0] wd,
                          input int dwb, input int drf, input bit rst_mid);
        cyc_t         q[$];
        int           set, hw, v, off, n;
        logic [25:0]  tg;
        logic [31:0]  la, rd, wa;
        logic [127:0] wl, rl;
        set = int'(a[5:4]);
        tg  = a[31:6];
        la  = {a[31:4], 4'h0};
        off = int'(a[3:0]) & (ty == 2 ? 12 : ty == 1 ? 14 : 15);
        n   = ty == 2 ? 4 : ty == 1 ? 2 : 1;
        hw  = -1;
        for (int w = 0; w < 2; w++) if (mv[set][w] && mt[set][w] == tg) hw = w;
        last_miss = hw < 0;
        last_wb_addr = '1;
        last_rf_addr = '1;
        q.push_back(mk(0, 0, 0, 0, rb(), 0, 0, 0));
        if (hw < 0) begin
            v = -1;
            for (int w = 1; w >= 0; w--) if (!mv[set][w]) v = w;
            if (v < 0) v = mp[set];
            if (mv[set][v] && md[set][v]) begin
                wa = {mt[set][v], a[5:4], 4'h0};
                wl = gline(wa);
                repeat (dwb) q.push_back(mk(0, 0, 1, 1, 0, 0, wa, wl));
                q.push_back(mk(0, 0, 1, 1, 1, 0, wa, wl));
                for (int k = 0; k < 16; k++) bmem[wa + k] = wl[8*k +: 8];
            end
            rl = bline(la);
            repeat (drf) q.push_back(mk(0, 0, 1, 0, 0, 0, la, rl));
            q.push_back(mk(0, 0, 1, 0, 1, 0, la, rl));
            if (mv[set][v]) mp[set] = (mp[set] + 1) % 2;
            mv[set][v] = 1;
            md[set][v] = 0;
            mt[set][v] = tg;
            hw = v;
            q.push_back(mk(0, 0, 0, 0, rb(), 0, 0, 0));
        end
        rd = '0;
        for (int k = 0; k < n; k++) begin
            if (we) gmem[la + off + k] = wd[8*k +: 8];
            else rd |= 32'(gget(la + off + k)) << (8 * k);
        end
        if (we) md[set][hw] = 1;
        q.push_back(mk(0, 1, 0, 0, rb(), rd, 0, 0));
        ex = mk(1, 0, 0, 0, rb(), 0, 0, 0);
        mem_gnt_i   = ex.gnt;
        req_valid_i = 1;
        req_we_i    = we;
        req_type_i  = memop_data_type_e'(2'(ty));
        req_addr_i  = a;
        req_wdata_i = wd;
        @(posedge clk_i);
        #1;
        foreach (q[i]) begin
            ex = q[i];
            mem_gnt_i   = ex.gnt;
            mem_rline_i = ex.line;
            req_valid_i = rb();
            req_we_i    = rb();
            req_type_i  = memop_data_type_e'(2'($urandom_range(0, 2)));
            req_addr_i  = $urandom;
            req_wdata_i = $urandom;
            if (rst_mid && ex.req && !ex.we) begin
                req_valid_i = 0;
                mem_gnt_i = 0;
                chk("mid-refill mem_req before reset", mem_req_o, 1'b1);
                do_reset();
                @(negedge clk_i);
                chk("ready after reset", req_ready_o, 1'b1);
                @(posedge clk_i);
                #1;
                return;
            end
            @(negedge clk_i);
            if (ex.rsp) last_rdata = rsp_rdata_o;
            if (ex.req && ex.we) begin
                last_wb_addr = mem_addr_o;
                last_wline   = mem_wline_o;
            end
            if (ex.req && !ex.we) last_rf_addr = mem_addr_o;
            @(posedge clk_i);
            #1;
        end
        req_valid_i = 0;
        ex = mk(1, 0, 0, 0, rb(), 0, 0, 0);
        mem_gnt_i = ex.gnt;
    endtask

    initial begin
        do_reset();
        @(negedge clk_i);
        chk("reset ready", req_ready_o, 1'b1);
        chk("reset rsp_valid", rsp_valid_o, 1'b0);
        chk("reset rsp_rdata", rsp_rdata_o, 32'h0);
        chk("reset mem_we", mem_we_o, 1'b0);
        chk("reset mem_addr", mem_addr_o, 32'h0);
        chk("reset mem_wline", mem_wline_o, 128'h0);
        @(posedge clk_i);
        #1;
        do_req(0, 2, 32'h100, 0, 0, 2, 0);
        chk("t1 refill addr", last_rf_addr, 32'h100);
        chk("t1 rdata", last_rdata, 32'h03020100);
        do_req(0, 2, 32'h100, 0, 0, 0, 0);
        chk("t1 reread model hit", last_miss, 1'b0);
        chk("t1 reread no refill", last_rf_addr, 32'hFFFF_FFFF);
        chk("t1 reread rdata", last_rdata, 32'h03020100);
        do_req(1, 0, 32'h105, 32'hAB, 0, 0, 0);
        chk("t2 store no refill", last_rf_addr, 32'hFFFF_FFFF);
        do_req(0, 2, 32'h104, 0, 0, 0, 0);
        chk("t2 rdata", last_rdata, 32'h0706AB04);
        do_req(0, 1, 32'h10F, 0, 0, 0, 0);
        chk("t6 half rdata", last_rdata, 32'h00000F0E);
        do_req(0, 2, 32'h140, 0, 0, 1, 0);
        do_req(0, 2, 32'h180, 0, 2, 1, 0);
        chk("t3 wb addr", last_wb_addr, 32'h100);
        chk("t3 wb byte5", last_wline[47:40], 8'hAB);
        chk("t3 refill addr", last_rf_addr, 32'h180);
        do_req(0, 2, 32'h100, 0, 0, 0, 0);
        chk("t3 reload model miss", last_miss, 1'b1);
        chk("t3 reload refill addr", last_rf_addr, 32'h100);
        do_req(0, 2, 32'h200, 0, 0, 10, 0);
        chk("t4 refill addr", last_rf_addr, 32'h200);
        do_req(0, 2, 32'h300, 0, 0, 3, 1);
        do_req(0, 2, 32'h104, 0, 0, 0, 0);
        chk("t5 miss after reset", last_rf_addr, 32'h100);
        chk("t5 written-back data", last_rdata, 32'h0706AB04);
        for (int i = 0; i < 400; i++) begin
            idle_cycles($urandom_range(0, 2));
            do_req(rb(), $urandom_range(0, 2), 32'($urandom_range(0, 1023)), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 39) == 0);
        end
        idle_cycles(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
